call_panel: RTL and testbench
=============================

CALL_PANEL -- requirements
Module: call_panel

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 5, number of floors and button bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles needed to accept a button level change.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port raw_btn  input  NUM_FLOORS  asynchronous, bouncy hall/cab pushbuttons, one per floor.
REQ-006 SHALL have port current_floor  input  3  floor reported by the elevator controller.
REQ-007 SHALL have port door_open  input  1  high while the car door is open at current_floor.
REQ-008 SHALL have port buttons  output  NUM_FLOORS  registered pending-request vector driven to the elevator controller's buttons input.
REQ-009 SHALL have port served  output  NUM_FLOORS  registered one-cycle pulse per floor when its pending request is cleared.
REQ-010 SHALL have port pending_count  output  3  registered population count of buttons.

Function
REQ-011 SHALL pass each raw_btn bit through a 2-flop synchronizer before any other use.
REQ-012 SHALL run a per-floor debounce FSM with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 RELEASED -> PRESS_WAIT when the synchronized bit is 1; the counter loads 1.
REQ-014 PRESS_WAIT: counter increments while the bit stays 1; -> PRESSED on the edge the counter reaches DEBOUNCE_CYCLES; -> RELEASED, counter cleared, if the bit returns to 0.
REQ-015 PRESSED -> RELEASE_WAIT and RELEASE_WAIT -> RELEASED/PRESSED SHALL mirror REQ-013/014 with polarity inverted.
REQ-016 Counter width SHALL be clog2(DEBOUNCE_CYCLES+1); it SHALL never wrap.
REQ-017 A press event SHALL be the PRESS_WAIT -> PRESSED transition only; holding a button SHALL generate no further events.
REQ-018 On a press event, buttons[i] SHALL set on that same edge: the 6th rising edge (2 sync + DEBOUNCE_CYCLES) after raw_btn[i] is first sampled high, for default parameters.
REQ-019 buttons[i] SHALL clear on any edge where door_open=1 and current_floor==i.
REQ-020 Clear SHALL win over a simultaneous press event on the same floor; a press at the open-door floor is discarded.
REQ-021 Set and clear on different floors in the same cycle SHALL both take effect.
REQ-022 served[i] SHALL pulse high for exactly one cycle on the edge buttons[i] goes 1 -> 0; no pulse if the bit was already 0.
REQ-023 current_floor >= NUM_FLOORS SHALL clear nothing.
REQ-024 pending_count SHALL equal the popcount of the buttons value being registered on the same edge, i.e. it tracks buttons with zero lag.
REQ-025 Repeated presses of an already-pending floor SHALL leave buttons unchanged.

Reset
REQ-026 While rst=1: buttons=0, served=0, pending_count=0, sync flops=0, all FSMs RELEASED, counters=0, taking effect immediately without a clock.
REQ-027 A button held through reset deassertion SHALL be treated as a new press after full sync+debounce latency.
REQ-028 Reset mid-debounce SHALL discard the partial count.

Structure
REQ-029 NUM_FLOORS default, floor-index width (3) and the debounce state encoding SHALL live in shared package elevator_pkg, also used by the elevator controller.
REQ-030 Sync plus debounce FSM SHALL be one sub-module, btn_debounce, instantiated NUM_FLOORS times via generate; call_panel holds the pending, served and count logic.

Verification
REQ-031 raw_btn[3] held high from reset release -> buttons=5'b01000 on 6th edge, pending_count=1.
REQ-032 raw_btn[1] glitch high 3 cycles then low -> buttons stays 0, no served pulse.
REQ-033 buttons=5'b10010; current_floor=4, door_open=1 for 1 cycle -> buttons=5'b00010, served=5'b10000 for exactly 1 cycle, pending_count=1.
REQ-034 door_open=1 at floor 2 while raw_btn[2] debounces -> buttons[2] never sets, served stays 0.
REQ-035 Same edge: press event floor 0 and clear floor 3 -> buttons 5'b01000 becomes 5'b00001.
REQ-036 rst pulsed mid-PRESS_WAIT on floor 2 with buttons=5'b00100 -> all outputs 0 asynchronously; held button re-sets buttons[2] 6 edges after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared elevator constants: floor count default, floor-index width and the
// button debounce state encoding used by both the call panel and the controller.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 5;
    localparam int FLOOR_W        = 3;

    localparam logic [1:0] DB_RELEASED     = 2'd0;
    localparam logic [1:0] DB_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] DB_PRESSED      = 2'd2;
    localparam logic [1:0] DB_RELEASE_WAIT = 2'd3;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchronizer then a 4-state debounce FSM; press pulses
// combinationally for the single cycle whose edge moves PRESS_WAIT -> PRESSED.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic [1:0]    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // The counter reaches DEBOUNCE_CYCLES on the accepting edge and is reloaded
    // before it is ever incremented again, so it cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DB_RELEASED;
            cnt   <= '0;
        end else begin
            case (state)
                DB_RELEASED: begin
                    if (sync_b) begin
                        state <= DB_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!sync_b) begin
                        state <= DB_RELEASED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt >= CNT_LAST) state <= DB_PRESSED;
                    end
                end
                DB_PRESSED: begin
                    if (!sync_b) begin
                        state <= DB_RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                default: begin
                    if (sync_b) begin
                        state <= DB_PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                        if (cnt >= CNT_LAST) state <= DB_RELEASED;
                    end
                end
            endcase
        end
    end

    assign press = (state == DB_PRESS_WAIT) && sync_b && (cnt >= CNT_LAST);

endmodule

// File: rtl/call_panel.sv
// Call panel: debounced button presses latch into a pending-request vector that
// clears when the door opens at that floor; served and pending_count are registered.
module call_panel
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS      = NUM_FLOORS_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] raw_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [NUM_FLOORS-1:0] buttons,
    output logic [NUM_FLOORS-1:0] served,
    output logic [2:0]            pending_count
);

    logic [NUM_FLOORS-1:0] press;
    logic [NUM_FLOORS-1:0] clear;
    logic [NUM_FLOORS-1:0] buttons_next;
    logic [2:0]            count_next;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .press(press[i])
        );
    end

    // An out-of-range floor matches no bit, so it clears nothing; clear beats press.
    always_comb begin
        clear      = '0;
        count_next = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clear[i] = door_open && (current_floor == FLOOR_W'(i));
        end
        buttons_next = (buttons | press) & ~clear;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            count_next = count_next + 3'(buttons_next[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buttons       <= '0;
            served        <= '0;
            pending_count <= '0;
        end else begin
            buttons       <= buttons_next;
            served        <= buttons & ~buttons_next;
            pending_count <= count_next;
        end
    end

endmodule

// File: tb/tb_call_panel.sv
// Bench for call_panel: directed scenarios with hand-derived values plus a
// randomized run against a sample-window reference model.
module tb_call_panel;

    localparam int NF = 5;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NF-1:0] raw_btn = '0;
    logic [2:0]    current_floor = '0;
    logic          door_open = 1'b0;
    logic [NF-1:0] buttons;
    logic [NF-1:0] served;
    logic [2:0]    pending_count;

    int checks = 0;
    int failures = 0;

    call_panel #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_btn      (raw_btn),
        .current_floor(current_floor),
        .door_open    (door_open),
        .buttons      (buttons),
        .served       (served),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    // Reference model: a floor's debounced level flips once the last D
    // synchronized samples (raw delayed two edges) all disagree with it.
    logic [NF-1:0] hist [0:D+1];
    logic [NF-1:0] m_level, m_buttons, m_served, m_ev, m_clr, m_nb;
    logic [2:0]    m_count;
    logic          all_on, all_off;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j <= D + 1; j++) hist[j] = '0;
            m_level = '0; m_buttons = '0; m_served = '0; m_count = '0;
        end else begin
            for (int j = D + 1; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = raw_btn;
            m_ev = '0;
            for (int f = 0; f < NF; f++) begin
                all_on = 1'b1; all_off = 1'b1;
                for (int j = 2; j <= D + 1; j++) begin
                    if (hist[j][f]) all_off = 1'b0; else all_on = 1'b0;
                end
                if (!m_level[f] && all_on) begin
                    m_level[f] = 1'b1;
                    m_ev[f] = 1'b1;
                end else if (m_level[f] && all_off) begin
                    m_level[f] = 1'b0;
                end
            end
            m_clr = (door_open && current_floor < NF) ? (NF'(1) << current_floor) : '0;
            m_nb = (m_buttons | m_ev) & ~m_clr;
            m_served = m_buttons & ~m_nb;
            m_count = 3'($countones(m_nb));
            m_buttons = m_nb;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        raw_btn = '0; door_open = 1'b0; current_floor = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        raw_btn = 5'b11111;
        rst = 1'b1;
        #1;
        checks++;
        if (buttons !== 5'b0 || served !== 5'b0 || pending_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_immediate: buttons=%b served=%b count=%0d, required all zero", buttons, served, pending_count);
        end
        repeat (8) @(negedge clk);
        checks++;
        if (buttons !== 5'b0 || pending_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_held: buttons=%b count=%0d, required zero while rst=1", buttons, pending_count);
        end
        raw_btn = '0;
        rst = 1'b0;
    endtask

    task automatic test_hold_press();
        @(negedge clk);
        rst = 1'b1; raw_btn = 5'b01000; door_open = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (buttons !== 5'b00000) begin
            failures++;
            $display("FAIL hold_edge5: buttons=%b, required 00000", buttons);
        end
        @(negedge clk);
        checks++;
        if (buttons !== 5'b01000 || pending_count !== 3'd1) begin
            failures++;
            $display("FAIL hold_edge6: buttons=%b count=%0d, required 01000 / 1", buttons, pending_count);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (buttons !== 5'b01000 || served !== 5'b0) begin
            failures++;
            $display("FAIL hold_no_repeat: buttons=%b served=%b, required 01000 / 00000", buttons, served);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        raw_btn = 5'b00010;
        repeat (3) @(negedge clk);
        raw_btn = 5'b00000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (buttons !== 5'b0 || served !== 5'b0) begin
                failures++;
                $display("FAIL glitch cycle %0d: buttons=%b served=%b, required 00000 / 00000", c, buttons, served);
            end
        end
    endtask

    task automatic test_clear();
        do_reset();
        raw_btn = 5'b10010;
        repeat (6) @(negedge clk);
        raw_btn = 5'b00000;
        checks++;
        if (buttons !== 5'b10010 || pending_count !== 3'd2) begin
            failures++;
            $display("FAIL clear_setup: buttons=%b count=%0d, required 10010 / 2", buttons, pending_count);
        end
        door_open = 1'b1; current_floor = 3'd4;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (buttons !== 5'b00010 || served !== 5'b10000 || pending_count !== 3'd1) begin
            failures++;
            $display("FAIL clear_edge: buttons=%b served=%b count=%0d, required 00010 / 10000 / 1", buttons, served, pending_count);
        end
        @(negedge clk);
        checks++;
        if (served !== 5'b00000 || buttons !== 5'b00010) begin
            failures++;
            $display("FAIL clear_pulse_width: served=%b buttons=%b, required 00000 / 00010", served, buttons);
        end
        door_open = 1'b1; current_floor = 3'd4;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (served !== 5'b00000 || buttons !== 5'b00010) begin
            failures++;
            $display("FAIL clear_empty_floor: served=%b buttons=%b, required 00000 / 00010", served, buttons);
        end
    endtask

    task automatic test_door_block();
        do_reset();
        door_open = 1'b1; current_floor = 3'd2;
        raw_btn = 5'b00100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (buttons[2] !== 1'b0 || served !== 5'b0) begin
                failures++;
                $display("FAIL door_block cycle %0d: buttons=%b served=%b, required bit2=0 / 00000", c, buttons, served);
            end
        end
        door_open = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (buttons !== 5'b0) begin
            failures++;
            $display("FAIL door_block_hold: buttons=%b, required 00000", buttons);
        end
        raw_btn = '0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        raw_btn = 5'b01000;
        repeat (6) @(negedge clk);
        raw_btn = 5'b00000;
        repeat (8) @(negedge clk);
        raw_btn = 5'b00001;
        repeat (5) @(negedge clk);
        door_open = 1'b1; current_floor = 3'd3;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (buttons !== 5'b00001 || served !== 5'b01000 || pending_count !== 3'd1) begin
            failures++;
            $display("FAIL simul_set_clear: buttons=%b served=%b count=%0d, required 00001 / 01000 / 1", buttons, served, pending_count);
        end
        raw_btn = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw_btn = 5'b00100;
        repeat (6) @(negedge clk);
        checks++;
        if (buttons !== 5'b00100) begin
            failures++;
            $display("FAIL rstmid_setup: buttons=%b, required 00100", buttons);
        end
        raw_btn = 5'b00000;
        repeat (8) @(negedge clk);
        raw_btn = 5'b00100;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (buttons !== 5'b0 || served !== 5'b0 || pending_count !== 3'd0) begin
            failures++;
            $display("FAIL rstmid_async: buttons=%b served=%b count=%0d, required all zero", buttons, served, pending_count);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (buttons !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_edge5: buttons=%b, required 00000", buttons);
        end
        @(negedge clk);
        checks++;
        if (buttons !== 5'b00100 || pending_count !== 3'd1) begin
            failures++;
            $display("FAIL rstmid_edge6: buttons=%b count=%0d, required 00100 / 1", buttons, pending_count);
        end
        raw_btn = '0;
    endtask

    task automatic test_random();
        int hold [NF];
        do_reset();
        for (int f = 0; f < NF; f++) hold[f] = $urandom_range(1, 10);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (buttons !== m_buttons || served !== m_served || pending_count !== m_count) begin
                failures++;
                $display("FAIL random cycle %0d: buttons=%b served=%b count=%0d, required %b / %b / %0d",
                         c, buttons, served, pending_count, m_buttons, m_served, m_count);
            end
            for (int f = 0; f < NF; f++) begin
                hold[f]--;
                if (hold[f] <= 0) begin
                    raw_btn[f] = ~raw_btn[f];
                    hold[f] = $urandom_range(1, 10);
                end
            end
            door_open = ($urandom_range(0, 5) == 0);
            current_floor = 3'($urandom_range(0, 7));
        end
        raw_btn = '0; door_open = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold_press();
        test_glitch();
        test_clear();
        test_door_block();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
